// File: rtl/tape_loader_pkg.sv
// rtl/tape_loader_pkg.sv - shared widths and FSM encoding for the tape loader
package tape_loader_pkg;
  localparam int WORD_W = 31;
  localparam int ADDR_W = 12;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    WAIT,
    DONE
  } state_t;
endpackage

// File: rtl/tape_loader_if.sv
// rtl/tape_loader_if.sv - reader byte stream and memory write port of the tape loader
interface tape_loader_if;
  import tape_loader_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;

  logic              mem_write_to_mem;
  logic [ADDR_W-1:0] sel_value_to_mem;
  logic              write_sign_to_mem;
  logic [WORD_W-2:0] write_data_to_mem;
  logic              mem_write_reply_from_mem;

  modport master (
    input  in_valid, in_data, mem_write_reply_from_mem,
    output in_ready, mem_write_to_mem, sel_value_to_mem, write_sign_to_mem, write_data_to_mem
  );

  modport slave (
    output in_valid, in_data, mem_write_reply_from_mem,
    input  in_ready, mem_write_to_mem, sel_value_to_mem, write_sign_to_mem, write_data_to_mem
  );
endinterface

// File: rtl/tape_loader_byte_packer.sv
// rtl/tape_loader_byte_packer.sv - assembles four reader bytes into one 31-bit word
module byte_packer
  import tape_loader_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              accept,
  input  logic [BYTE_W-1:0] byte_data,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);
  logic [1:0] idx;

  // Flags the byte that completes the word, so the FSM can leave RECV on that same edge.
  assign word_full = accept && (idx == 2'(BYTES_PER_WORD - 1));

  // The word is not cleared between loads: it is the held write data seen by memory.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      idx  <= '0;
      word <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (accept) begin
      idx <= word_full ? 2'd0 : idx + 2'd1;
      case (idx)
        2'd0:    word[7:0]   <= byte_data;
        2'd1:    word[15:8]  <= byte_data;
        2'd2:    word[23:16] <= byte_data;
        default: word[30:24] <= byte_data[6:0];
      endcase
    end
  end
endmodule

// File: rtl/tape_loader.sv
// rtl/tape_loader.sv - loads a block of tape words into memory and reports a checksum
module tape_loader
  import tape_loader_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start_from_op,
  input  logic [ADDR_W-1:0] start_addr_from_op,
  input  logic [ADDR_W-1:0] word_count_from_op,
  input  logic              abort_from_op,
  tape_loader_if.master     bus,
  output logic              busy_to_op,
  output logic              done_to_op,
  output logic [WORD_W-1:0] checksum_to_op
);
  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   count;
  logic                in_ready;
  logic                mem_write;
  logic                abort_pend;
  logic [WORD_W-1:0]   word;
  logic                word_full;
  logic                accept;
  logic                clear;

  assign accept = bus.in_valid && in_ready;
  assign clear  = (state == IDLE);

  byte_packer #(.BYTES_PER_WORD(BYTES_PER_WORD)) u_packer (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (clear),
    .accept    (accept),
    .byte_data (bus.in_data),
    .word      (word),
    .word_full (word_full)
  );

  assign bus.in_ready          = in_ready;
  assign bus.mem_write_to_mem  = mem_write;
  assign bus.sel_value_to_mem  = addr;
  assign bus.write_sign_to_mem = word[30];
  assign bus.write_data_to_mem = word[29:0];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= IDLE;
      addr           <= '0;
      count          <= '0;
      in_ready       <= 1'b0;
      mem_write      <= 1'b0;
      abort_pend     <= 1'b0;
      busy_to_op     <= 1'b0;
      done_to_op     <= 1'b0;
      checksum_to_op <= '0;
    end else begin
      mem_write  <= 1'b0;
      done_to_op <= 1'b0;
      case (state)
        IDLE: begin
          if (abort_from_op) begin
            state      <= DONE;
            busy_to_op <= 1'b1;
            done_to_op <= 1'b1;
          end else if (start_from_op) begin
            addr           <= start_addr_from_op;
            count          <= word_count_from_op;
            checksum_to_op <= '0;
            abort_pend     <= 1'b0;
            busy_to_op     <= 1'b1;
            if (word_count_from_op == '0) begin
              state      <= DONE;
              done_to_op <= 1'b1;
            end else begin
              state    <= RECV;
              in_ready <= 1'b1;
            end
          end
        end
        RECV: begin
          // Abort wins over a word completing in the same cycle: the partial word is dropped.
          if (abort_from_op) begin
            state      <= DONE;
            in_ready   <= 1'b0;
            done_to_op <= 1'b1;
          end else if (word_full) begin
            state     <= WRITE;
            in_ready  <= 1'b0;
            mem_write <= 1'b1;
          end
        end
        WRITE: begin
          state <= WAIT;
          if (abort_from_op) abort_pend <= 1'b1;
        end
        WAIT: begin
          if (abort_from_op) abort_pend <= 1'b1;
          if (bus.mem_write_reply_from_mem) begin
            checksum_to_op <= checksum_to_op + word;
            addr           <= addr + 1'b1;
            count          <= count - 1'b1;
            if (count == 12'd1 || abort_from_op || abort_pend) begin
              state      <= DONE;
              done_to_op <= 1'b1;
            end else begin
              state    <= RECV;
              in_ready <= 1'b1;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          busy_to_op <= 1'b0;
          abort_pend <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tape_loader.sv
// tb/tb_tape_loader.sv - randomized self-checking bench for tape_loader against a block-load model
module tb_tape_loader;
  import tape_loader_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] start_addr = '0;
  logic [11:0] word_count = '0;
  logic        busy;
  logic        done;
  logic [30:0] checksum;

  tape_loader_if bus ();

  tape_loader dut (
    .clk                (clk),
    .resetn             (resetn),
    .start_from_op      (start),
    .start_addr_from_op (start_addr),
    .word_count_from_op (word_count),
    .abort_from_op      (abort),
    .bus                (bus),
    .busy_to_op         (busy),
    .done_to_op         (done),
    .checksum_to_op     (checksum)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  byte_q[$];
  int          consumed = 0;
  bit          rand_valid = 1'b0;
  int          reply_delay = 2;
  logic [42:0] writes[$];
  int          strobes = 0;
  int          done_pulses = 0;
  bit          ready_seen = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reader: presents queued bytes, optionally with random gaps, pops on handshake.
  bit acc;
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    forever begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (acc && byte_q.size() > 0) begin
        void'(byte_q.pop_front());
        consumed++;
      end
      if (byte_q.size() > 0 && (!rand_valid || $urandom_range(1, 0) == 1)) begin
        bus.in_valid = 1'b1;
        bus.in_data  = byte_q[0];
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
      end
    end
  end

  // Memory: records each strobe, replies reply_delay cycles later, checks hold and no early strobe.
  logic [11:0] w_addr;
  logic [30:0] w_word;
  initial begin
    bus.mem_write_reply_from_mem = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_write_to_mem && resetn) begin
        w_addr = bus.sel_value_to_mem;
        w_word = {bus.write_sign_to_mem, bus.write_data_to_mem};
        writes.push_back({w_addr, w_word});
        strobes++;
        for (int i = 1; i <= reply_delay; i++) begin
          @(posedge clk);
          #1;
          if (i == reply_delay) bus.mem_write_reply_from_mem = 1'b1;
          @(negedge clk);
          chk("hold_addr", 64'(bus.sel_value_to_mem), 64'(w_addr));
          chk("hold_word", 64'({bus.write_sign_to_mem, bus.write_data_to_mem}), 64'(w_word));
          chk("no_early_strobe", 64'(bus.mem_write_to_mem), 64'd0);
          if (!resetn) break;
        end
        @(posedge clk);
        #1 bus.mem_write_reply_from_mem = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (done) done_pulses++;
    if (bus.in_ready) ready_seen = 1'b1;
  end

  task automatic pulse_start(input logic [11:0] a, input logic [11:0] n);
    @(posedge clk);
    #1;
    start_addr = a;
    word_count = n;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    start_addr = 12'($urandom);
    word_count = 12'($urandom);
  endtask

  // Expected result derived straight from the queued bytes: n words, consecutive wrapping addresses.
  task automatic run_load(input string tag, input logic [11:0] a, input int n, input int exp_cycles);
    logic [42:0] exp[$];
    logic [30:0] sum;
    logic [30:0] w;
    int          cyc;
    sum = '0;
    for (int i = 0; i < n; i++) begin
      w = {byte_q[4*i+3][6:0], byte_q[4*i+2], byte_q[4*i+1], byte_q[4*i]};
      exp.push_back({12'(int'(a) + i), w});
      sum = sum + w;
    end
    writes.delete();
    done_pulses = 0;
    ready_seen  = 1'b0;
    pulse_start(a, 12'(n));
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    end while (!done && cyc < 2000);
    chk({tag, "_done_seen"}, 64'(done), 64'd1);
    if (exp_cycles > 0) chk({tag, "_cycles"}, 64'(cyc), 64'(exp_cycles));
    if (n == 0) begin
      chk({tag, "_count0_latency"}, 64'(cyc <= 2), 64'd1);
      chk({tag, "_count0_no_ready"}, 64'(ready_seen), 64'd0);
    end
    chk({tag, "_busy_in_done"}, 64'(busy), 64'd1);
    chk({tag, "_checksum"}, 64'(checksum), 64'(sum));
    chk({tag, "_write_count"}, 64'(writes.size()), 64'(n));
    for (int i = 0; i < n && i < writes.size(); i++)
      chk({tag, "_write"}, 64'(writes[i]), 64'(exp[i]));
    @(negedge clk);
    chk({tag, "_single_done"}, 64'(done_pulses), 64'd1);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_checksum_held"}, 64'(checksum), 64'(sum));
  endtask

  task automatic push_random(input int nbytes);
    for (int i = 0; i < nbytes; i++) byte_q.push_back(8'($urandom));
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_strobe"}, 64'(bus.mem_write_to_mem), 64'd0);
    chk({tag, "_addr"}, 64'(bus.sel_value_to_mem), 64'd0);
    chk({tag, "_sign"}, 64'(bus.write_sign_to_mem), 64'd0);
    chk({tag, "_data"}, 64'(bus.write_data_to_mem), 64'd0);
    chk({tag, "_ready"}, 64'(bus.in_ready), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_checksum"}, 64'(checksum), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  logic [30:0] w0;
  int          base;
  int          bound;
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk);
    #1 resetn = 1'b1;

    // Single directed word: byte3 bit 7 must be dropped.
    byte_q = '{8'h78, 8'h56, 8'h34, 8'h92};
    run_load("single", 12'o0100, 1, 8);
    chk("single_value", 64'(writes.size() > 0 ? writes[0] : 43'd0), 64'({12'o0100, 31'h12345678}));

    // Full-rate block crossing the top of memory.
    push_random(12);
    run_load("wrap", 12'o7776, 3, 22);

    run_load("count0", 12'o0055, 0, 0);

    // Gappy byte stream with a slow memory.
    rand_valid  = 1'b1;
    reply_delay = 5;
    push_random(12);
    run_load("stall", 12'o7777, 3, 0);
    for (int k = 0; k < 3; k++) begin
      reply_delay = int'($urandom_range(5, 2));
      base = int'($urandom_range(4, 1));
      push_random(4 * base);
      run_load("random", 12'($urandom), base, 0);
    end
    rand_valid  = 1'b0;
    reply_delay = 2;

    // Abort after two bytes of a word.
    push_random(2);
    base = consumed;
    strobes = 0;
    done_pulses = 0;
    pulse_start(12'o0200, 12'd1);
    bound = 0;
    do begin
      @(posedge clk);
      #2;
      bound++;
    end while (consumed < base + 2 && bound < 100);
    chk("abort_recv_bytes", 64'(consumed - base), 64'd2);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_recv_done", 64'(done), 64'd1);
    repeat (4) @(negedge clk);
    chk("abort_recv_no_strobe", 64'(strobes), 64'd0);
    chk("abort_recv_checksum", 64'(checksum), 64'd0);
    chk("abort_recv_done_once", 64'(done_pulses), 64'd1);

    // Abort while waiting for the reply: the in-flight word still counts.
    reply_delay = 5;
    push_random(12);
    w0 = {byte_q[3][6:0], byte_q[2], byte_q[1], byte_q[0]};
    writes.delete();
    strobes = 0;
    pulse_start(12'o1234, 12'd3);
    bound = 0;
    do begin
      @(posedge clk);
      #2;
      bound++;
    end while (strobes == 0 && bound < 100);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    bound = 0;
    do begin
      @(negedge clk);
      bound++;
    end while (!done && bound < 100);
    chk("abort_wait_done", 64'(done), 64'd1);
    chk("abort_wait_writes", 64'(writes.size()), 64'd1);
    chk("abort_wait_word", 64'(writes.size() > 0 ? writes[0] : 43'd0), 64'({12'o1234, w0}));
    chk("abort_wait_checksum", 64'(checksum), 64'(w0));
    byte_q.delete();
    repeat (3) @(negedge clk);

    // Reset while waiting for a reply, then a normal load.
    reply_delay = 6;
    push_random(8);
    strobes = 0;
    pulse_start(12'o4321, 12'd2);
    bound = 0;
    do begin
      @(posedge clk);
      #2;
      bound++;
    end while (strobes == 0 && bound < 100);
    chk("reset_wait_strobe_seen", 64'(strobes), 64'd1);
    resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    byte_q.delete();
    @(negedge clk);
    check_zero_outputs("reset_wait");
    repeat (8) @(negedge clk);
    reply_delay = 2;
    push_random(4);
    run_load("after_reset", 12'o0007, 1, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
